// File: rtl/fifomult_arb_pkg.sv
// Shared types and helpers for the fifomult2024 request arbiter.
// Holds the FSM state encoding, the response error bit positions and
// the parity helper used on operand and product words.
package fifomult_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SEND_A,
    SEND_B,
    WAIT_RES,
    RESP
  } state_t;

  localparam int ERR_IN_PAR  = 0;
  localparam int ERR_TIMEOUT = 1;
  localparam int ERR_OUT_PAR = 2;

  // Narrower words are zero-extended by the caller; zeros leave the XOR unchanged.
  function automatic logic parity(input logic [63:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/fifomult_arbiter_rr_arbiter.sv
// Round-robin grant picker: first asserted req at or after last_grant+1.
// Latency: combinational. Backpressure: none, grant is all-zero when en is low.
// Ports: req (request vector), last_grant (pointer), en -> grant (one-hot), grant_idx.
module rr_arbiter #(
  parameter int N_REQ = 4,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last_grant,
  input  logic             en,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] grant_idx
);

  logic [IDX_W-1:0] idx;
  logic             found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = '0;
    // Walk N_REQ positions starting just after the previous winner.
    for (int i = 1; i <= N_REQ; i++) begin
      idx = IDX_W'((int'(last_grant) + i) % N_REQ);
      if (en && !found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/fifomult_arbiter.sv
// Shares one fifomult2024 multiplier among N_REQ requesters, one transaction at a time.
// Latency: accept c0, operand A c1, operand B c2, response one cycle after product strobe.
// Backpressure: req_ready pulses only in IDLE with mul_busy low; responses cannot be stalled.
// Ports: clk/rst; req_valid/req_a/req_b/req_ready requester side; resp_* response side;
//        mul_* multiplier side (all multiplier inputs except clk and reset).
// Optional: define FIFOMULT_ARB_OUT_PARITY_CHECK_EN to check product parity into resp_err[2].
module fifomult_arbiter
  import fifomult_arb_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*DATA_W-1:0]   req_a,
  input  logic [N_REQ*DATA_W-1:0]   req_b,
  output logic [N_REQ-1:0]          req_ready,
  output logic                      resp_valid,
  output logic [$clog2(N_REQ)-1:0]  resp_id,
  output logic [2*DATA_W-1:0]       resp_data,
  output logic [2:0]                resp_err,
  output logic [DATA_W-1:0]         mul_data_in,
  output logic                      mul_data_in_parity,
  output logic                      mul_data_in_valid,
  input  logic                      mul_busy,
  input  logic [2*DATA_W-1:0]       mul_data_out,
  input  logic                      mul_data_out_parity,
  input  logic                      mul_data_out_valid,
  input  logic                      mul_data_in_parity_error
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t               state_q;
  logic [IDX_W-1:0]     last_grant_q;
  logic [IDX_W-1:0]     g_q;
  logic [DATA_W-1:0]    b_q;
  logic                 in_perr_q;
  logic [CNT_W-1:0]     cnt_q;

  logic [DATA_W-1:0]    mul_data_q;
  logic                 mul_par_q;
  logic                 mul_vld_q;
  logic                 resp_valid_q;
  logic [IDX_W-1:0]     resp_id_q;
  logic [2*DATA_W-1:0]  resp_data_q;
  logic [2:0]           resp_err_q;

  logic [N_REQ-1:0]     grant;
  logic [IDX_W-1:0]     grant_idx;
  logic                 arb_en;
  logic [DATA_W-1:0]    sel_a;
  logic [DATA_W-1:0]    sel_b;
  logic                 out_par_err;

  // Reset is gated in so req_ready stays low while rst is held.
  assign arb_en = (state_q == IDLE) && !mul_busy && !rst;

  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .req        (req_valid),
    .last_grant (last_grant_q),
    .en         (arb_en),
    .grant      (grant),
    .grant_idx  (grant_idx)
  );

  assign sel_a = req_a[grant_idx*DATA_W +: DATA_W];
  assign sel_b = req_b[grant_idx*DATA_W +: DATA_W];

`ifdef FIFOMULT_ARB_OUT_PARITY_CHECK_EN
  assign out_par_err = parity(64'(mul_data_out)) ^ mul_data_out_parity;
`else
  logic unused_out_par;
  assign unused_out_par = mul_data_out_parity;
  assign out_par_err    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= IDX_W'(N_REQ - 1);
      g_q          <= '0;
      b_q          <= '0;
      in_perr_q    <= 1'b0;
      cnt_q        <= '0;
      mul_data_q   <= '0;
      mul_par_q    <= 1'b0;
      mul_vld_q    <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      resp_data_q  <= '0;
      resp_err_q   <= '0;
    end else begin
      mul_vld_q    <= 1'b0;
      resp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (|grant) begin
            g_q        <= grant_idx;
            b_q        <= sel_b;
            in_perr_q  <= 1'b0;
            mul_data_q <= sel_a;
            mul_par_q  <= parity(64'(sel_a));
            mul_vld_q  <= 1'b1;
            state_q    <= SEND_A;
          end
        end
        SEND_A: begin
          mul_data_q <= b_q;
          mul_par_q  <= parity(64'(b_q));
          mul_vld_q  <= 1'b1;
          state_q    <= SEND_B;
        end
        SEND_B: begin
          mul_data_q <= '0;
          mul_par_q  <= 1'b0;
          cnt_q      <= '0;
          if (mul_data_in_parity_error) in_perr_q <= 1'b1;
          state_q    <= WAIT_RES;
        end
        WAIT_RES: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (mul_data_in_parity_error) in_perr_q <= 1'b1;
          // Product has priority over a timeout landing in the same cycle.
          if (mul_data_out_valid) begin
            resp_valid_q             <= 1'b1;
            resp_id_q                <= g_q;
            resp_data_q              <= mul_data_out;
            resp_err_q[ERR_IN_PAR]   <= in_perr_q | mul_data_in_parity_error;
            resp_err_q[ERR_TIMEOUT]  <= 1'b0;
            resp_err_q[ERR_OUT_PAR]  <= out_par_err;
            state_q                  <= RESP;
          end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            resp_valid_q             <= 1'b1;
            resp_id_q                <= g_q;
            resp_data_q              <= '0;
            resp_err_q[ERR_IN_PAR]   <= in_perr_q | mul_data_in_parity_error;
            resp_err_q[ERR_TIMEOUT]  <= 1'b1;
            resp_err_q[ERR_OUT_PAR]  <= 1'b0;
            state_q                  <= RESP;
          end
        end
        RESP: begin
          resp_id_q    <= '0;
          resp_data_q  <= '0;
          resp_err_q   <= '0;
          last_grant_q <= g_q;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready          = grant;
  assign resp_valid         = resp_valid_q;
  assign resp_id            = resp_id_q;
  assign resp_data          = resp_data_q;
  assign resp_err           = resp_err_q;
  assign mul_data_in        = mul_data_q;
  assign mul_data_in_parity = mul_par_q;
  assign mul_data_in_valid  = mul_vld_q;

endmodule

// File: tb/tb_fifomult_arbiter.sv
// Self-checking bench for fifomult_arbiter with a behavioural multiplier
// and a response scoreboard filled at grant time, drained on resp_valid.
module tb_fifomult_arbiter;

  localparam int N   = 4;
  localparam int W   = 16;
  localparam int TMO = 64;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N-1:0]   req_valid, req_ready;
  logic [N*W-1:0] req_a, req_b;
  logic           resp_valid;
  logic [1:0]     resp_id;
  logic [2*W-1:0] resp_data;
  logic [2:0]     resp_err;
  logic [W-1:0]   mul_data_in;
  logic           mul_data_in_parity, mul_data_in_valid, mul_busy;
  logic [2*W-1:0] mul_data_out;
  logic           mul_data_out_parity, mul_data_out_valid, mul_data_in_parity_error;

  fifomult_arbiter #(.N_REQ(N), .DATA_W(W), .TIMEOUT(TMO)) dut (
    .clk                      (clk),
    .rst                      (rst),
    .req_valid                (req_valid),
    .req_a                    (req_a),
    .req_b                    (req_b),
    .req_ready                (req_ready),
    .resp_valid               (resp_valid),
    .resp_id                  (resp_id),
    .resp_data                (resp_data),
    .resp_err                 (resp_err),
    .mul_data_in              (mul_data_in),
    .mul_data_in_parity       (mul_data_in_parity),
    .mul_data_in_valid        (mul_data_in_valid),
    .mul_busy                 (mul_busy),
    .mul_data_out             (mul_data_out),
    .mul_data_out_parity      (mul_data_out_parity),
    .mul_data_out_valid       (mul_data_out_valid),
    .mul_data_in_parity_error (mul_data_in_parity_error)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    int          id;
    logic [31:0] data;
    logic [2:0]  err;
    int          acc;
    int          lat;
  } sb_t;

  sb_t sb_q[$];
  int  exp_gnt_q[$];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Test knobs
  logic [2:0] exp_err = 3'b000;
  int         exp_lat = 6;
  int         mdl_dly = 3;
  bit         mdl_drop = 0, mdl_bad_par = 0, mdl_perr = 0, stray_pulse = 0;

  // Requester agents
  int          rem[N];
  bit          use_fix[N];
  logic [15:0] fix_a[N], fix_b[N], cur_a[N], cur_b[N];
  bit          gnt_pend[N];

  // Multiplier model state
  int          nw = 0, mdl_cnt = 0;
  bit          perr_now = 0;
  logic [15:0] w0, w1, last_w0, last_w1;
  logic        last_p0, last_p1;

  int outstanding = 0, n_acc = 0, n_resp = 0, n_win = 0;

  always begin
    @(negedge clk);
    // Drive phase
    for (int i = 0; i < N; i++) begin
      if (gnt_pend[i]) begin
        req_valid[i] = 1'b0;
        gnt_pend[i]  = 1'b0;
      end
      if (!req_valid[i] && rem[i] > 0 && !rst) begin
        rem[i]--;
        cur_a[i] = use_fix[i] ? fix_a[i] : 16'($urandom);
        cur_b[i] = use_fix[i] ? fix_b[i] : 16'($urandom);
        req_a[i*W +: W] = cur_a[i];
        req_b[i*W +: W] = cur_b[i];
        req_valid[i] = 1'b1;
      end
    end
    mul_data_out_valid       = 1'b0;
    mul_data_in_parity_error = 1'b0;
    if (perr_now) begin
      mul_data_in_parity_error = 1'b1;
      perr_now = 0;
    end
    if (stray_pulse) begin
      mul_data_out_valid  = 1'b1;
      mul_data_out        = 32'hDEAD_BEEF;
      mul_data_out_parity = ^mul_data_out;
      stray_pulse = 0;
    end
    if (mdl_cnt > 0) begin
      mdl_cnt--;
      if (mdl_cnt == 0) begin
        mul_data_out        = {16'h0, w0} * {16'h0, w1};
        mul_data_out_parity = (^mul_data_out) ^ mdl_bad_par;
        mul_data_out_valid  = 1'b1;
      end
    end
    #2;
    // Sample phase
    if (|req_ready) begin
      int id;
      sb_t e;
      id = 0;
      for (int i = 0; i < N; i++) if (req_ready[i]) id = i;
      n_acc++;
      check_eq("ready_onehot", 64'($onehot(req_ready)), 64'd1);
      check_eq("one_outstanding", 64'(outstanding), 64'd0);
      if (exp_gnt_q.size() == 0) check_eq("unexpected_grant", 64'(id), 64'hFF);
      else check_eq("grant_order", 64'(id), 64'(exp_gnt_q.pop_front()));
      outstanding = 1;
      gnt_pend[id] = 1;
      e.id   = id;
      e.data = exp_err[1] ? 32'h0 : ({16'h0, cur_a[id]} * {16'h0, cur_b[id]});
      e.err  = exp_err;
      e.acc  = cyc;
      e.lat  = exp_lat;
      sb_q.push_back(e);
    end
    if (mul_data_in_valid) begin
      n_win++;
      check_eq("in_word_parity", 64'(mul_data_in_parity), 64'(^mul_data_in));
      if (nw == 0) begin
        w0 = mul_data_in; last_p0 = mul_data_in_parity; nw = 1;
      end else begin
        w1 = mul_data_in; last_p1 = mul_data_in_parity; nw = 0;
        last_w0 = w0; last_w1 = w1;
        if (!mdl_drop) mdl_cnt = mdl_dly;
        if (mdl_perr) perr_now = 1;
      end
    end
    if (resp_valid) begin
      n_resp++;
      outstanding = 0;
      if (sb_q.size() == 0) check_eq("unexpected_resp", 64'(resp_id), 64'hFF);
      else begin
        sb_t e;
        e = sb_q.pop_front();
        check_eq("resp_id", 64'(resp_id), 64'(e.id));
        check_eq("resp_data", 64'(resp_data), 64'(e.data));
        check_eq("resp_err", 64'(resp_err), 64'(e.err));
        check_eq("resp_latency", 64'(cyc - e.acc), 64'(e.lat));
      end
    end
  end

  task automatic wait_resp(input int target, input int budget);
    int k = 0;
    while (n_resp < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    #3;
    check_eq("resp_arrived", 64'(n_resp >= target), 64'd1);
  endtask

  task automatic check_outs_zero(input string tag);
    check_eq({tag, "_ready"}, 64'(req_ready), 64'd0);
    check_eq({tag, "_rvld"}, 64'(resp_valid), 64'd0);
    check_eq({tag, "_resp"}, 64'({resp_id, resp_data, resp_err}), 64'd0);
    check_eq({tag, "_mul"}, 64'({mul_data_in, mul_data_in_parity, mul_data_in_valid}), 64'd0);
  endtask

  task automatic do_reset(input bit chk);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #3;
    if (chk) check_outs_zero("abort");
    sb_q.delete();
    outstanding = 0; nw = 0; mdl_cnt = 0; perr_now = 0;
    for (int i = 0; i < N; i++) begin
      gnt_pend[i] = 0; rem[i] = 0; req_valid[i] = 1'b0;
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, acc0, win0;
    rst = 1'b1;
    req_valid = '0; req_a = '0; req_b = '0; mul_busy = 1'b0;
    mul_data_out = '0; mul_data_out_parity = 1'b0;
    mul_data_out_valid = 1'b0; mul_data_in_parity_error = 1'b0;
    for (int i = 0; i < N; i++) begin
      rem[i] = 0; use_fix[i] = 0; fix_a[i] = '0; fix_b[i] = '0; gnt_pend[i] = 0;
      cur_a[i] = '0; cur_b[i] = '0;
    end
    repeat (3) @(negedge clk);
    #3;
    check_outs_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Single request from requester 2: 3 * 5
    exp_gnt_q.push_back(2);
    use_fix[2] = 1; fix_a[2] = 16'h0003; fix_b[2] = 16'h0005;
    exp_err = 3'b000; mdl_dly = 1; exp_lat = 4;
    rem[2] = 1;
    wait_resp(1, 50);
    check_eq("word_a", 64'(last_w0), 64'h3);
    check_eq("word_b", 64'(last_w1), 64'h5);
    check_eq("par_a", 64'(last_p0), 64'd0);
    check_eq("par_b", 64'(last_p1), 64'd0);
    use_fix[2] = 0;

    // All four requesting after reset: 0,1,2,3,0
    do_reset(0);
    mdl_dly = 3; exp_lat = 6;
    exp_gnt_q.push_back(0); exp_gnt_q.push_back(1); exp_gnt_q.push_back(2);
    exp_gnt_q.push_back(3); exp_gnt_q.push_back(0);
    rem[0] = 2; rem[1] = 1; rem[2] = 1; rem[3] = 1;
    wait_resp(n_resp + 5, 200);

    // Multiplier busy blocks acceptance
    mul_busy = 1'b1;
    exp_gnt_q.push_back(0);
    rem[0] = 1;
    acc0 = n_acc; win0 = n_win;
    repeat (10) @(negedge clk);
    #3;
    check_eq("busy_no_accept", 64'(n_acc), 64'(acc0));
    check_eq("busy_no_word", 64'(n_win), 64'(win0));
    @(posedge clk); #1;
    mul_busy = 1'b0;
    @(negedge clk); #3;
    check_eq("busy_drop_accept", 64'(n_acc), 64'(acc0 + 1));
    wait_resp(n_resp + 1, 50);

    // Timeout: no product ever returned
    mdl_drop = 1; exp_err = 3'b010; exp_lat = 67;
    exp_gnt_q.push_back(1);
    rem[1] = 1;
    wait_resp(n_resp + 1, 200);

    // Product on the last WAIT_RES cycle wins over timeout
    mdl_drop = 0; mdl_dly = 64; exp_err = 3'b000; exp_lat = 67;
    exp_gnt_q.push_back(2);
    rem[2] = 1;
    wait_resp(n_resp + 1, 200);

    // Input parity error flagged by the multiplier while waiting
    mdl_dly = 3; exp_lat = 6; mdl_perr = 1; exp_err = 3'b001;
    exp_gnt_q.push_back(3);
    rem[3] = 1;
    wait_resp(n_resp + 1, 50);
    mdl_perr = 0;

    // Corrupted product parity
    mdl_bad_par = 1;
`ifdef FIFOMULT_ARB_OUT_PARITY_CHECK_EN
    exp_err = 3'b100;
`else
    exp_err = 3'b000;
`endif
    exp_gnt_q.push_back(0);
    rem[0] = 1;
    wait_resp(n_resp + 1, 50);
    mdl_bad_par = 0; exp_err = 3'b000;

    // Stray product strobe in IDLE is ignored
    base = n_resp;
    @(posedge clk); #1;
    stray_pulse = 1;
    repeat (5) @(negedge clk);
    #3;
    check_eq("stray_ignored", 64'(n_resp), 64'(base));

    // Reset mid-WAIT_RES aborts silently; pointer returns to requester 0 first
    exp_gnt_q.push_back(0);
    rem[0] = 1;
    wait_resp(n_resp + 1, 50);
    mdl_drop = 1;
    exp_gnt_q.push_back(1);
    rem[1] = 1;
    acc0 = n_acc;
    repeat (10) @(negedge clk);
    #3;
    check_eq("abort_accepted", 64'(n_acc), 64'(acc0 + 1));
    base = n_resp;
    do_reset(1);
    check_eq("abort_no_resp", 64'(n_resp), 64'(base));
    mdl_drop = 0; mdl_dly = 3; exp_lat = 6;
    exp_gnt_q.push_back(0); exp_gnt_q.push_back(2);
    rem[0] = 1; rem[2] = 1;
    wait_resp(n_resp + 2, 100);
    check_eq("gnt_queue_drained", 64'(exp_gnt_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fifomult_arbiter.md
Name: fifomult_arbiter

Overview:
Shares one fifomult2024 multiplier between N_REQ requesters.
- Selects a requester by round-robin and sends its operand pair to the multiplier as two parity-protected words.
- Waits for the product, then returns it with the requester ID and error flags.
- Sits between the requester agents and the multiplier. Drives every multiplier input except clk and reset.

Parameters:
N_REQ, 4, number of requesters (2..8)
DATA_W, 16, operand width; product width is 2*DATA_W
TIMEOUT, 64, maximum cycles in WAIT_RES before the transaction is aborted

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
req_valid  in  N_REQ  per-requester operand pair valid
req_a  in  N_REQ*DATA_W  operand A, requester i at [i*DATA_W +: DATA_W]
req_b  in  N_REQ*DATA_W  operand B, same packing as req_a
req_ready  out  N_REQ  one-hot 1-cycle accept pulse
resp_valid  out  1  1-cycle response pulse
resp_id  out  $clog2(N_REQ)  requester that owns the response
resp_data  out  2*DATA_W  product
resp_err  out  3  [0] input parity error, [1] timeout, [2] output parity error
mul_data_in  out  DATA_W  operand word to the multiplier
mul_data_in_parity  out  1  XOR reduction of mul_data_in
mul_data_in_valid  out  1  word strobe
mul_busy  in  1  multiplier busy_out
mul_data_out  in  2*DATA_W  multiplier product
mul_data_out_parity  in  1  multiplier output parity
mul_data_out_valid  in  1  product strobe
mul_data_in_parity_error  in  1  multiplier input parity error flag

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on port rst.
- Reset values: all outputs 0; state IDLE; round-robin pointer last_grant = N_REQ-1, so requester 0 has first priority. Reset mid-transaction aborts it with no response.
- State flow: IDLE -> SEND_A -> SEND_B -> WAIT_RES -> RESP -> IDLE.
- IDLE:
  - Start a transaction only if some req_valid is 1 and mul_busy is 0.
  - Grant the first valid requester at or after last_grant+1, wrapping modulo N_REQ.
  - In the same cycle: assert req_ready[g], latch a, b and g, clear the error bits.
  - Next state SEND_A.
- SEND_A: drive mul_data_in = a, parity = ^a, mul_data_in_valid = 1 for exactly one cycle, independent of mul_busy. Next SEND_B.
- SEND_B: same, with operand b. Next WAIT_RES; the timeout counter is cleared to 0.
- WAIT_RES:
  - Counter increments each cycle.
  - If mul_data_in_parity_error = 1 in SEND_B or WAIT_RES, set err[0] (sticky).
  - On mul_data_out_valid: capture mul_data_out and mul_data_out_parity; next RESP.
  - Else when counter reaches TIMEOUT-1: set err[1], data = 0, next RESP.
  - Product valid and timeout in the same cycle: the product wins and err[1] stays 0.
- RESP:
  - resp_valid = 1 for one cycle with resp_id, resp_data, resp_err. No backpressure.
  - last_grant is set to g. Next IDLE.
  - The next transaction is accepted one cycle after RESP at the earliest.
- Stray inputs: mul_data_out_valid outside WAIT_RES is ignored.
- Latency: with accept at cycle 0, A goes out at cycle 1 and B at cycle 2. resp_valid comes one cycle after the cycle in which mul_data_out_valid is seen.
- Requester protocol: req_valid must be held until req_ready. A requester that drops req_valid before being granted is skipped.
- resp_err[2] is 0 unless the optional feature is enabled.

Optional Feature:
- Macro: FIFOMULT_ARB_OUT_PARITY_CHECK_EN.
- When defined: on product capture, compare ^mul_data_out with mul_data_out_parity. On mismatch set resp_err[2]; resp_data is still returned.
- When undefined: no checker logic is built; resp_err[2] is tied to 0.
- Port list is identical in both builds.

Decomposition:
- Package fifomult_arb_pkg:
  - state enum (IDLE, SEND_A, SEND_B, WAIT_RES, RESP)
  - err bit index constants (ERR_IN_PAR = 0, ERR_TIMEOUT = 1, ERR_OUT_PAR = 2)
  - parity function returning the XOR reduction
- Sub-module rr_arbiter (N_REQ parameter): inputs req vector, last_grant and enable; outputs one-hot grant and encoded grant index. Purely combinational; the pointer register lives in fifomult_arbiter.

Test Plan:
- Single request: req 2 sends a = 16'h0003, b = 16'h0005 -> req_ready[2] at cycle 0; mul_data_in 0003 then 0005 with parity 0 then 0; resp_data = 32'h0000000F, resp_id = 2, resp_err = 0.
- All four requesting continuously after reset -> grants in order 0, 1, 2, 3, 0; exactly one transaction outstanding at a time.
- mul_busy held 1 with req 0 valid -> no req_ready and no mul_data_in_valid; busy drops -> accept in the next IDLE cycle.
- mul_data_out_valid never arrives -> after TIMEOUT = 64 cycles in WAIT_RES, resp_valid with resp_err = 3'b010 and resp_data = 0.
- Multiplier raises data_in_parity_error during WAIT_RES -> resp_err[0] = 1. With FIFOMULT_ARB_OUT_PARITY_CHECK_EN defined and a corrupted mul_data_out_parity -> resp_err[2] = 1.
- rst = 1 during WAIT_RES -> next cycle all outputs 0 and state IDLE; no resp_valid for the aborted request; req 0 granted first afterwards.
